// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full-adder cell plus a carry flop, LSB first, IDLE/RUN/DONE control.
// Optional macro SERIAL_ADDER_OVF_EN adds a registered signed-overflow output ovf.
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
`ifdef SERIAL_ADDER_OVF_EN
    output logic             ovf,
`endif
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    // Holds bits 0..WIDTH-2; the final bit joins them directly on the load into sum.
    logic [WIDTH-2:0] res_sh_q, res_sh_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    // Full-adder cell built from two half adders and an OR.
    logic ha1_s, ha1_c, ha2_s, ha2_c;
    logic fa_sum, fa_cout;

    always_comb begin
        ha1_s   = a_sh_q[0] ^ b_sh_q[0];
        ha1_c   = a_sh_q[0] & b_sh_q[0];
        ha2_s   = ha1_s ^ carry_q;
        ha2_c   = ha1_s & carry_q;
        fa_sum  = ha2_s;
        fa_cout = ha1_c | ha2_c;
    end

    logic [WIDTH-2:0] res_shifted;

    generate
        if (WIDTH > 2) begin : g_res_wide
            assign res_shifted = {fa_sum, res_sh_q[WIDTH-2:1]};
        end else begin : g_res_narrow
            assign res_shifted = (WIDTH-1)'(fa_sum);
        end
    endgenerate

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_sh_d = res_sh_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        sum_d    = sum_q;
        cout_d   = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
        ovf_d    = ovf_q;
`endif

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_RUN;
                    a_sh_d  = a;
                    b_sh_d  = b;
                    carry_d = 1'b0;
                    cnt_d   = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_RUN: begin
                a_sh_d   = {1'b0, a_sh_q[WIDTH-1:1]};
                b_sh_d   = {1'b0, b_sh_q[WIDTH-1:1]};
                res_sh_d = res_shifted;
                carry_d  = fa_cout;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_BIT) begin
                    state_d = S_DONE;
                    sum_d   = {fa_sum, res_sh_q};
                    cout_d  = fa_cout;
`ifdef SERIAL_ADDER_OVF_EN
                    // carry_q is the carry into the MSB on this last edge.
                    ovf_d   = carry_q ^ fa_cout;
`endif
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_sh_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_sh_q <= res_sh_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            sum_q    <= sum_d;
            cout_q   <= cout_d;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign busy = (state_q == S_RUN);
    assign done = (state_q == S_DONE);
    assign sum  = sum_q;
    assign cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (WIDTH=8): occupancy/arithmetic model plus directed vectors.
module tb_serial_adder_ctrl;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic         ovf;
`endif

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
`ifdef SERIAL_ADDER_OVF_EN
        .ovf   (ovf),
`endif
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit check_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", nm, act, req, $time);
        end
    endtask

    // Model: an accepted request occupies W+1 cycles (W busy, 1 done); the result is a+b.
    int           m_rem  = 0;
    logic [W:0]   m_pend = '0;
    logic         m_pend_ovf = 1'b0;
    logic [W-1:0] m_sum  = '0;
    logic         m_cout = 1'b0;
    logic         m_ovf  = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_rem  <= 0;
            m_sum  <= '0;
            m_cout <= 1'b0;
            m_ovf  <= 1'b0;
        end else if (m_rem <= 1 && start) begin
            m_rem      <= W + 1;
            m_pend     <= {1'b0, a} + {1'b0, b};
            m_pend_ovf <= (a[W-1] == b[W-1]) && (((a + b) >> (W - 1)) & 1) != a[W-1];
        end else if (m_rem > 0) begin
            m_rem <= m_rem - 1;
            if (m_rem == 2) begin
                m_sum  <= m_pend[W-1:0];
                m_cout <= m_pend[W];
                m_ovf  <= m_pend_ovf;
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            chk("model_busy", {31'd0, busy}, {31'd0, m_rem > 1});
            chk("model_done", {31'd0, done}, {31'd0, m_rem == 1});
            chk("model_sum",  {24'd0, sum},  {24'd0, m_sum});
            chk("model_cout", {31'd0, cout}, {31'd0, m_cout});
`ifdef SERIAL_ADDER_OVF_EN
            chk("model_ovf",  {31'd0, ovf},  {31'd0, m_ovf});
`endif
        end
    end

    // Called at the first negedge after an accepting edge (k=1); returns at the done negedge.
    task automatic wait_done(input bit toggle, output int k, output int busy_n, output bit seen);
        k = 1;
        busy_n = 0;
        seen = 1'b0;
        while (k <= 20 && !seen) begin
            if (done) begin
                seen = 1'b1;
            end else begin
                if (busy) busy_n++;
                if (toggle) begin
                    a = 8'($urandom);
                    b = 8'($urandom);
                end
                @(negedge clk);
                k++;
            end
        end
    endtask

    task automatic do_op(input logic [7:0] av, input logic [7:0] bv,
                         input logic [7:0] es, input logic ec, input logic eo);
        int k, bn;
        bit seen;
        @(negedge clk);
        start = 1'b1;
        a = av;
        b = bv;
        @(negedge clk);
        start = 1'b0;
        wait_done(1'b1, k, bn, seen);
        chk("op_done_seen", {31'd0, seen}, 32'd1);
        chk("op_latency",   k,  32'd9);
        chk("op_busy_cnt",  bn, 32'd8);
        chk("op_sum",  {24'd0, sum},  {24'd0, es});
        chk("op_cout", {31'd0, cout}, {31'd0, ec});
`ifdef SERIAL_ADDER_OVF_EN
        chk("op_ovf",  {31'd0, ovf},  {31'd0, eo});
`else
        if (eo === 1'bx) $display("note: ovf expectation unknown");
`endif
        $display("op a=0x%02h b=0x%02h -> sum=0x%02h cout=%0b latency=%0d", av, bv, sum, cout, k);
    endtask

    initial begin
        int k, bn, dcount;
        bit seen;

        rst = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_en = 1'b1;
        @(negedge clk);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_sum",  {24'd0, sum},  32'd0);
        chk("reset_cout", {31'd0, cout}, 32'd0);
        $display("reset released, idle");

        do_op(8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
        do_op(8'hFF, 8'h01, 8'h00, 1'b1, 1'b0);
        do_op(8'hFF, 8'hFF, 8'hFE, 1'b1, 1'b0);
        do_op(8'h7F, 8'h01, 8'h80, 1'b0, 1'b1);
        do_op(8'h80, 8'h80, 8'h00, 1'b1, 1'b1);
        do_op(8'hA5, 8'h3C, 8'hE1, 1'b0, 1'b0);

        // Back-to-back with start held high.
        @(negedge clk);
        start = 1'b1;
        a = 8'h0F;
        b = 8'h01;
        @(negedge clk);
        wait_done(1'b1, k, bn, seen);
        chk("b2b_first_seen", {31'd0, seen}, 32'd1);
        chk("b2b_first_lat",  k, 32'd9);
        chk("b2b_first_sum",  {24'd0, sum}, 32'h10);
        chk("b2b_first_cout", {31'd0, cout}, 32'd0);
        $display("op a=0x0f b=0x01 -> sum=0x%02h cout=%0b latency=%0d (back-to-back 1)", sum, cout, k);
        a = 8'h10;
        b = 8'h10;
        @(negedge clk);
        chk("b2b_no_idle", {31'd0, busy}, 32'd1);
        wait_done(1'b1, k, bn, seen);
        start = 1'b0;
        chk("b2b_second_seen", {31'd0, seen}, 32'd1);
        chk("b2b_second_lat",  k, 32'd9);
        chk("b2b_second_sum",  {24'd0, sum}, 32'h20);
        chk("b2b_second_cout", {31'd0, cout}, 32'd0);
        $display("op a=0x10 b=0x10 -> sum=0x%02h cout=%0b latency=%0d (back-to-back 2)", sum, cout, k);
        @(negedge clk);
        chk("b2b_back_idle", {31'd0, busy}, 32'd0);

        // Reset wins over start on the same edge.
        rst = 1'b1;
        start = 1'b1;
        a = 8'h11;
        b = 8'h22;
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        chk("rst_prio_busy", {31'd0, busy}, 32'd0);
        chk("rst_prio_sum",  {24'd0, sum},  32'd0);
        $display("reset with start: stayed idle");

        // Reload a nonzero result, then abort a run with reset on its 4th RUN edge.
        do_op(8'h21, 8'h12, 8'h33, 1'b0, 1'b0);
        @(negedge clk);
        start = 1'b1;
        a = 8'h55;
        b = 8'h55;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_sum",  {24'd0, sum},  32'd0);
        chk("abort_cout", {31'd0, cout}, 32'd0);
        dcount = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) dcount++;
        end
        chk("abort_no_done", dcount, 32'd0);
        $display("op a=0x55 b=0x55 aborted by reset, done pulses afterwards=%0d", dcount);

        check_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
